// File: rtl/macc_pkg.sv
// Shared defaults and pacing FSM state encoding for the MACC sample pacer.
package macc_pkg;

  localparam int unsigned DATA_W_DEFAULT  = 18;
  localparam int unsigned DEPTH_DEFAULT   = 16;
  localparam int unsigned SPACING_DEFAULT = 16;

  typedef enum logic [1:0] {
    PACE_IDLE = 2'd0,
    PACE_EMIT = 2'd1,
    PACE_GAP  = 2'd2
  } pace_state_t;

endpackage

// File: rtl/macc_sample_fifo.sv
// Synchronous sample FIFO with push, pop and registered occupancy level.
// A push into a full FIFO is accepted only when a pop happens at the same edge.
module macc_sample_fifo #(
  parameter int unsigned DATA_W = 18,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head_c,
  output logic                     empty_c,
  output logic                     full_c,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign empty_c = (level == '0);
  assign full_c  = (level == LVL_W'(DEPTH));
  assign head_c  = mem[rd_ptr];
  assign pop_ok  = pop & ~empty_c;
  assign push_ok = push & (~full_c | pop_ok);

  // Storage array carries no reset; validity is tracked by level.
  always_ff @(posedge clk) begin
    if (push_ok && !rst) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/macc_sample_pacer.sv
// Buffers bursty samples and releases them at most one per SPACING clocks to a
// single-MAC filter. Define MACC_PACER_STATS_EN to add the DropCnt_o counter.
module macc_sample_pacer
  import macc_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEFAULT,
  parameter int unsigned DEPTH   = DEPTH_DEFAULT,
  parameter int unsigned SPACING = SPACING_DEFAULT
) (
  input  logic                   Clk_i,
  input  logic                   Rst_i,
  input  logic [DATA_W-1:0]      Data_i,
  input  logic                   DataNd_i,
  output logic [DATA_W-1:0]      Data_o,
  output logic                   DataNd_o,
  output logic [$clog2(DEPTH):0] Level_o,
  output logic                   Overflow_o
`ifdef MACC_PACER_STATS_EN
  ,
  output logic [15:0]            DropCnt_o
`endif
);

  localparam int unsigned CNT_W = (SPACING > 2) ? $clog2(SPACING) : 1;

  pace_state_t       state;
  logic [CNT_W-1:0]  gap_cnt;
  logic [DATA_W-1:0] head_c;
  logic              empty_c;
  logic              full_c;
  logic              push_c;
  logic              pop_c;
  logic              drop_c;

  assign push_c = DataNd_i & ~Rst_i;
  // Pop whenever a sample is waiting and the previous strobe is SPACING edges old.
  assign pop_c  = ~empty_c &
                  ((state == PACE_IDLE) | ((state == PACE_GAP) & (gap_cnt == '0)));
  assign drop_c = push_c & full_c & ~pop_c;

  macc_sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (Clk_i),
    .rst     (Rst_i),
    .push    (push_c),
    .wdata   (Data_i),
    .pop     (pop_c),
    .head_c  (head_c),
    .empty_c (empty_c),
    .full_c  (full_c),
    .level   (Level_o)
  );

  // EMIT is the strobe cycle; GAP counts the remaining SPACING-2 quiet cycles.
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      state      <= PACE_IDLE;
      gap_cnt    <= '0;
      Data_o     <= '0;
      DataNd_o   <= 1'b0;
      Overflow_o <= 1'b0;
    end else begin
      DataNd_o   <= pop_c;
      Overflow_o <= drop_c;
      if (pop_c) Data_o <= head_c;
      case (state)
        PACE_IDLE: begin
          gap_cnt <= '0;
          if (pop_c) state <= PACE_EMIT;
        end
        PACE_EMIT: begin
          state   <= PACE_GAP;
          gap_cnt <= CNT_W'(SPACING - 2);
        end
        PACE_GAP: begin
          if (gap_cnt != '0) gap_cnt <= gap_cnt - CNT_W'(1);
          else if (pop_c)    state   <= PACE_EMIT;
          else               state   <= PACE_IDLE;
        end
        default: begin
          state   <= PACE_IDLE;
          gap_cnt <= '0;
        end
      endcase
    end
  end

`ifdef MACC_PACER_STATS_EN
  // Saturating count of samples dropped on a full FIFO.
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      DropCnt_o <= '0;
    end else if (drop_c && (DropCnt_o != 16'hFFFF)) begin
      DropCnt_o <= DropCnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_macc_sample_pacer.sv
// Directed and randomized checks of macc_sample_pacer against a queue-based
// timing model: a sample leaves when queued and SPACING edges have passed.
module tb_macc_sample_pacer;

  localparam int unsigned DATA_W  = 18;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned SPACING = 16;

  logic              clk = 1'b0;
  logic              Rst_i;
  logic [DATA_W-1:0] Data_i;
  logic              DataNd_i;
  logic [DATA_W-1:0] Data_o;
  logic              DataNd_o;
  logic [4:0]        Level_o;
  logic              Overflow_o;
`ifdef MACC_PACER_STATS_EN
  logic [15:0]       DropCnt_o;
`endif

  macc_sample_pacer #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .SPACING (SPACING)
  ) dut (
    .Clk_i      (clk),
    .Rst_i      (Rst_i),
    .Data_i     (Data_i),
    .DataNd_i   (DataNd_i),
    .Data_o     (Data_o),
    .DataNd_o   (DataNd_o),
    .Level_o    (Level_o),
    .Overflow_o (Overflow_o)
`ifdef MACC_PACER_STATS_EN
    ,
    .DropCnt_o  (DropCnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [DATA_W-1:0] q[$];
  int                cyc = 0;
  int                last_pop = 0;
  bit                have_last = 0;
  logic              exp_nd = 0;
  logic              exp_ovf = 0;
  logic [DATA_W-1:0] exp_data = '0;
  int                exp_drops = 0;

  // Observation log
  logic [DATA_W-1:0] emit_val[$];
  int                emit_cyc[$];
  int                ovf_seen = 0;
  int                max_level = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clear_log();
    emit_val.delete();
    emit_cyc.delete();
    ovf_seen  = 0;
    max_level = 0;
  endtask

  // One clock: drive inputs, advance the model, compare every output.
  task automatic step(input logic nd, input logic [DATA_W-1:0] d, input logic rst);
    bit pop;
    @(negedge clk);
    Rst_i    = rst;
    DataNd_i = nd;
    Data_i   = d;
    if (rst) begin
      q.delete();
      have_last = 0;
      exp_nd    = 0;
      exp_ovf   = 0;
      exp_data  = '0;
      exp_drops = 0;
    end else begin
      pop     = (q.size() > 0) && (!have_last || (cyc - last_pop) >= int'(SPACING));
      exp_nd  = pop;
      exp_ovf = 0;
      if (pop) begin
        exp_data  = q.pop_front();
        last_pop  = cyc;
        have_last = 1;
      end
      if (nd) begin
        if (q.size() < int'(DEPTH)) q.push_back(d);
        else begin
          exp_ovf = 1;
          if (exp_drops < 65535) exp_drops++;
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
    check("data_nd", 32'(DataNd_o), 32'(exp_nd));
    check("data", 32'(Data_o), 32'(exp_data));
    check("level", 32'(Level_o), 32'(q.size()));
    check("overflow", 32'(Overflow_o), 32'(exp_ovf));
`ifdef MACC_PACER_STATS_EN
    check("drop_cnt", 32'(DropCnt_o), 32'(exp_drops));
`endif
    if (DataNd_o === 1'b1) begin
      emit_val.push_back(Data_o);
      emit_cyc.push_back(cyc);
    end
    if (Overflow_o === 1'b1) ovf_seen++;
    if (int'(Level_o) > max_level) max_level = int'(Level_o);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
  endtask

  initial begin
    logic [DATA_W-1:0] sine_vals[$];
    logic [DATA_W-1:0] v;
    int                rate;

    Rst_i    = 1'b1;
    DataNd_i = 1'b0;
    Data_i   = '0;

    // Reset state, with a strobe that must be ignored
    step(1'b0, '0, 1'b1);
    step(1'b1, 18'h1234, 1'b1);
    check("reset_level", 32'(Level_o), 32'd0);
    check("reset_data_nd", 32'(DataNd_o), 32'd0);
    idle(20);

    // Single sample: strobe exactly two edges after the write
    clear_log();
    step(1'b1, 18'h0ABCD, 1'b0);
    check("single_early", 32'(DataNd_o), 32'd0);
    step(1'b0, '0, 1'b0);
    check("single_nd", 32'(DataNd_o), 32'd1);
    check("single_data", 32'(Data_o), 32'h0ABCD);
    check("single_level", 32'(Level_o), 32'd0);
    idle(20);
    check("single_count", 32'(emit_val.size()), 32'd1);

    // Burst of four: exactly SPACING between strobes
    clear_log();
    for (int i = 1; i <= 4; i++) step(1'b1, DATA_W'(i), 1'b0);
    idle(70);
    check("burst_count", 32'(emit_val.size()), 32'd4);
    for (int i = 0; i < emit_val.size(); i++) begin
      check("burst_val", 32'(emit_val[i]), 32'(i + 1));
      if (i > 0) check("burst_gap", 32'(emit_cyc[i] - emit_cyc[i-1]), 32'd16);
    end

    // Overflow: 20 back-to-back writes, last two dropped
    step(1'b0, '0, 1'b1);
    idle(4);
    clear_log();
    for (int i = 1; i <= 20; i++) step(1'b1, DATA_W'(100 + i), 1'b0);
    idle(18 * 16 + 20);
    check("ovf_pulses", 32'(ovf_seen), 32'd2);
    check("ovf_count", 32'(emit_val.size()), 32'd18);
    for (int i = 0; i < emit_val.size(); i++)
      check("ovf_order", 32'(emit_val[i]), 32'(101 + i));
`ifdef MACC_PACER_STATS_EN
    check("ovf_dropcnt", 32'(DropCnt_o), 32'd2);
`endif

    // Steady rate sine, one sample per SPACING clocks
    clear_log();
    for (int i = 0; i < 32; i++) begin
      v = DATA_W'($rtoi(65536.0 * $sin(2.0 * 3.14159265358979 * i / 32.0)));
      sine_vals.push_back(v);
      step(1'b1, v, 1'b0);
      idle(15);
    end
    idle(20);
    check("sine_count", 32'(emit_val.size()), 32'd32);
    check("sine_max_level", 32'(max_level), 32'd1);
    check("sine_no_ovf", 32'(ovf_seen), 32'd0);
    for (int i = 0; i < emit_val.size() && i < 32; i++)
      check("sine_val", 32'(emit_val[i]), 32'(sine_vals[i]));

    // Reset mid-burst discards buffered samples
    for (int i = 1; i <= 6; i++) step(1'b1, DATA_W'(200 + i), 1'b0);
    check("midrst_level_before", 32'(Level_o), 32'd5);
    step(1'b1, 18'h3FFFF, 1'b1);
    check("midrst_level_after", 32'(Level_o), 32'd0);
    clear_log();
    idle(40);
    check("midrst_silent", 32'(emit_val.size()), 32'd0);

    // Negative full-scale sample passes unchanged
    step(1'b1, 18'h20000, 1'b0);
    step(1'b0, '0, 1'b0);
    check("neg_nd", 32'(DataNd_o), 32'd1);
    check("neg_data", 32'(Data_o), 32'h20000);
    idle(20);

    // Randomized traffic at several rates with occasional resets
    for (int ph = 0; ph < 4; ph++) begin
      rate = (ph == 0) ? 3 : (ph == 1) ? 6 : (ph == 2) ? 30 : 90;
      for (int i = 0; i < 500; i++) begin
        step(($urandom_range(0, 99) < rate) ? 1'b1 : 1'b0,
             DATA_W'($urandom),
             ($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0);
      end
    end
    idle(300);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/macc_sample_pacer.md
MACC_SAMPLE_PACER -- requirements
Module: macc_sample_pacer

Interface
REQ-001 SHALL have parameter DATA_W, default 18, sample width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, FIFO depth in samples; power of two, at least 2.
REQ-003 SHALL have parameter SPACING, default 16, minimum clocks between output strobes; at least 2; equals the downstream single-MAC filter tap count.
REQ-004 SHALL have: Clk_i  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have: Rst_i  in  1  reset, synchronous, active-high.
REQ-006 SHALL have: Data_i  in  DATA_W  signed input sample.
REQ-007 SHALL have: DataNd_i  in  1  new-sample strobe, one cycle per sample, arbitrary rate.
REQ-008 SHALL have: Data_o  out  DATA_W  paced sample to the filter's Data_i.
REQ-009 SHALL have: DataNd_o  out  1  one-cycle strobe to the filter's DataNd_i.
REQ-010 SHALL have: Level_o  out  log2(DEPTH)+1  current FIFO occupancy.
REQ-011 SHALL have: Overflow_o  out  1  one-cycle pulse per dropped sample.

Function
REQ-012 SHALL write Data_i into the FIFO at the edge where DataNd_i=1 and (Level<DEPTH or a pop occurs at the same edge).
REQ-013 SHALL drop the sample when DataNd_i=1, Level=DEPTH and no pop occurs; Overflow_o=1 in the following cycle; FIFO contents unchanged.
REQ-014 SHALL run a pacing FSM: IDLE (gap counter 0) -> EMIT when FIFO not empty; EMIT pops the head; EMIT -> GAP with counter loaded to SPACING-2 (-> IDLE directly if SPACING=2 and empty, -> EMIT if SPACING=2 and non-empty); GAP decrements; at 0, -> EMIT if non-empty, else IDLE.
REQ-015 SHALL register Data_o and DataNd_o: popped sample appears with DataNd_o=1 for exactly one cycle after the pop edge.
REQ-016 SHALL hold Data_o at the last emitted value while DataNd_o=0.
REQ-017 SHALL separate consecutive DataNd_o pulses by at least SPACING cycles, and exactly SPACING while the FIFO is non-empty.
REQ-018 SHALL give latency 2 edges from a DataNd_i sample into an empty FIFO in IDLE to DataNd_o=1.
REQ-019 SHALL preserve sample order, value and sign bit-exactly.
REQ-020 SHALL wrap read/write pointers modulo DEPTH; Level_o updates registered at the same edge as the push/pop.
REQ-021 SHALL, on simultaneous push and pop, leave Level unchanged.

Reset
REQ-022 SHALL, with Rst_i=1 at an edge, clear pointers, Level_o=0, FSM=IDLE, counter=0, Data_o=0, DataNd_o=0, Overflow_o=0.
REQ-023 SHALL, on reset mid-operation, discard buffered samples; no DataNd_o until a new sample is written after reset release.
REQ-024 SHALL ignore DataNd_i while Rst_i=1.

Configuration
REQ-025 SHALL, with MACC_PACER_STATS_EN defined, add output DropCnt_o (16 bits), counting dropped samples, saturating at 0xFFFF, cleared by reset.
REQ-026 SHALL, without MACC_PACER_STATS_EN, omit DropCnt_o and its counter; all other behaviour identical.

Structure
REQ-027 SHALL take DATA_W default, SPACING default and the FSM state enumeration from shared package macc_pkg.
REQ-028 SHALL implement storage as sub-module macc_sample_fifo (synchronous FIFO with push, pop, level); FSM and output registers in the top.

Verification
REQ-029 SHALL verify single sample: 0x0ABCD written from idle -> Data_o=0x0ABCD, DataNd_o=1 exactly 2 edges later, single pulse, Level_o back to 0.
REQ-030 SHALL verify burst: 4 back-to-back samples 1,2,3,4 -> DataNd_o at cycles t, t+16, t+32, t+48 carrying 1,2,3,4.
REQ-031 SHALL verify overflow: 20 back-to-back writes (DEPTH=16) -> writes 19 and 20 dropped, two Overflow_o pulses, 18 samples output in order, DropCnt_o=2 when enabled.
REQ-032 SHALL verify steady rate: one DataNd_i every 16 cycles of a 2^16-amplitude sine -> every sample output once, Level_o never exceeds 1, no Overflow_o.
REQ-033 SHALL verify reset mid-burst: Rst_i asserted one cycle with Level_o=5 -> Level_o=0, no DataNd_o afterwards until a new write.
REQ-034 SHALL verify negative sample 0x20000 -> Data_o=0x20000 unchanged.
